// File: rtl/cordic_pkg.sv
// Shared constants for the 16-iteration rotation-mode cosine pipeline.
// Angles, gain and datapath values are signed Q2.22.
package cordic_pkg;

  localparam int unsigned InW      = 21;
  localparam int unsigned DataW    = 24;
  localparam int unsigned Iters    = 16;
  localparam int unsigned PerStage = 4;
  localparam int unsigned Stages   = Iters / PerStage;

  typedef logic signed [DataW-1:0] fix_t;

  // Inverse CORDIC gain, so the final x is cos() without a post-scale
  localparam fix_t KScale = 24'sd2547003;

  function automatic fix_t atan_lut(input int unsigned idx);
    case (idx)
      0:       atan_lut = 24'sd3294199;
      1:       atan_lut = 24'sd1944679;
      2:       atan_lut = 24'sd1027515;
      3:       atan_lut = 24'sd521583;
      4:       atan_lut = 24'sd261803;
      5:       atan_lut = 24'sd131029;
      6:       atan_lut = 24'sd65531;
      7:       atan_lut = 24'sd32767;
      8:       atan_lut = 24'sd16384;
      9:       atan_lut = 24'sd8192;
      10:      atan_lut = 24'sd4096;
      11:      atan_lut = 24'sd2048;
      12:      atan_lut = 24'sd1024;
      13:      atan_lut = 24'sd512;
      14:      atan_lut = 24'sd256;
      15:      atan_lut = 24'sd128;
      default: atan_lut = '0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_rotate4.sv
// Four consecutive rotation-mode micro-rotations starting at iteration Base.
// Purely combinational; shifts are arithmetic and truncating.
module cordic_rotate4
  import cordic_pkg::*;
#(
  parameter int unsigned Base = 0
) (
  input  fix_t x,
  input  fix_t y,
  input  fix_t z,
  output fix_t x_rot,
  output fix_t y_rot,
  output fix_t z_rot
);

  fix_t xs, ys, zs, xt;

  always_comb begin
    xs = x;
    ys = y;
    zs = z;
    xt = x;
    for (int unsigned k = 0; k < PerStage; k++) begin
      // Negative residual angle rotates clockwise (d = -1)
      if (zs[DataW-1]) begin
        xt = xs + (ys >>> (Base + k));
        ys = ys - (xs >>> (Base + k));
        zs = zs + atan_lut(Base + k);
      end else begin
        xt = xs - (ys >>> (Base + k));
        ys = ys + (xs >>> (Base + k));
        zs = zs - atan_lut(Base + k);
      end
      xs = xt;
    end
    x_rot = xs;
    y_rot = ys;
    z_rot = zs;
  end

endmodule

// File: rtl/cordic_unroll4_var_fixed_point_input.sv
// Pipelined cosine: four 4-iteration CORDIC stages, then a registered
// fixed-to-float stage. done marks result for the operand LATENCY cycles back.
module cordic_unroll4_var_fixed_point_input
  import cordic_pkg::*;
#(
  // Must match the datapath depth (Stages + 1 float stage)
  parameter int unsigned LATENCY = 5
) (
  input  logic           clock,
  input  logic           aclr,
  input  logic           clk_en,
  input  logic           start,
  input  logic [InW-1:0] dataa,
  output logic [31:0]    result,
  output logic           done
);

  fix_t x_src [Stages];
  fix_t y_src [Stages];
  fix_t z_src [Stages];
  fix_t x_rot [Stages];
  fix_t y_rot [Stages];
  fix_t z_rot [Stages];
  fix_t x_q   [Stages];
  fix_t y_q   [Stages];
  fix_t z_q   [Stages];

  logic [LATENCY-1:0] valid_q;
  logic [31:0]        float_d;
  fix_t               x_fin;

  // Q1.20 angle sign-extended and scaled into Q2.22
  assign x_src[0] = KScale;
  assign y_src[0] = '0;
  assign z_src[0] = fix_t'({dataa[InW-1], dataa, 2'b00});

  for (genvar s = 0; s < Stages; s++) begin : g_stage
    if (s > 0) begin : g_chain
      assign x_src[s] = x_q[s-1];
      assign y_src[s] = y_q[s-1];
      assign z_src[s] = z_q[s-1];
    end
    cordic_rotate4 #(
      .Base(s * PerStage)
    ) u_rotate4 (
      .x    (x_src[s]),
      .y    (y_src[s]),
      .z    (z_src[s]),
      .x_rot(x_rot[s]),
      .y_rot(y_rot[s]),
      .z_rot(z_rot[s])
    );
  end

  always_ff @(posedge clock) begin
    if (!aclr) begin
      for (int unsigned s = 0; s < Stages; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
        z_q[s] <= '0;
      end
      valid_q <= '0;
      result  <= '0;
    end else if (clk_en) begin
      for (int unsigned s = 0; s < Stages; s++) begin
        x_q[s] <= x_rot[s];
        y_q[s] <= y_rot[s];
        z_q[s] <= z_rot[s];
      end
      valid_q <= {valid_q[LATENCY-2:0], start};
      if (valid_q[LATENCY-2]) begin
        result <= float_d;
      end
    end
  end

  assign x_fin = x_q[Stages-1];

  // x lands in [0.54, 1.0]: exponent 126 below 1.0, saturate at or above it
  always_comb begin
    float_d = 32'h0000_0000;
    if (!x_fin[DataW-1] && x_fin[DataW-2]) begin
      float_d = 32'h3F80_0000;
    end else if (!x_fin[DataW-1] && x_fin[DataW-3]) begin
      float_d = {1'b0, 8'd126, x_fin[DataW-4:0], 2'b00};
    end
  end

  assign done = valid_q[LATENCY-1];

  logic unused_tail;
  assign unused_tail = ^{y_q[Stages-1], z_q[Stages-1]};

endmodule

// File: tb/tb_cordic_unroll4_var_fixed_point_input.sv
// Randomised and directed bench for the pipelined cosine unit against a
// real-valued cos() reference with a 2^-14 absolute tolerance.
module tb_cordic_unroll4_var_fixed_point_input;

  localparam real Tol = 6.103515625e-5;

  logic        clock;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [20:0] dataa;
  logic [31:0] result;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Reference: operand tags travelling through a 5-slot enabled delay line
  bit  mv [5];
  real ma [5];
  bit  have_last;
  real last_angle;

  cordic_unroll4_var_fixed_point_input #(
    .LATENCY(5)
  ) dut (
    .clock (clock),
    .aclr  (aclr),
    .clk_en(clk_en),
    .start (start),
    .dataa (dataa),
    .result(result),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic real to_angle(input logic [20:0] a);
    return real'($signed(a)) / 1048576.0;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23]) - 127)));
    return b[31] ? -v : v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    real err;
    check_val("done", 32'(done), 32'(mv[4]));
    if (!have_last) begin
      check_val("result_zero", result, 32'h0);
    end else begin
      err = f2r(result) - $cos(last_angle);
      if (err < 0.0) err = -err;
      check_val($sformatf("cos_tol a=%f res=%h", last_angle, result), 32'(err <= Tol), 32'd1);
    end
  endtask

  task automatic step(input logic s, input logic [20:0] a, input logic en, input logic rn);
    start  = s;
    dataa  = a;
    clk_en = en;
    aclr   = rn;
    @(posedge clock);
    if (!rn) begin
      for (int i = 0; i < 5; i++) mv[i] = 1'b0;
      have_last = 1'b0;
    end else if (en) begin
      for (int i = 4; i > 0; i--) begin
        mv[i] = mv[i-1];
        ma[i] = ma[i-1];
      end
      mv[0] = s;
      ma[0] = to_angle(a);
      if (mv[4]) begin
        have_last  = 1'b1;
        last_angle = ma[4];
      end
    end
    @(negedge clock);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 21'h0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      mv[i] = 1'b0;
      ma[i] = 0.0;
    end
    have_last  = 1'b0;
    last_angle = 0.0;
    start = 1'b0; dataa = '0; clk_en = 1'b0; aclr = 1'b0;

    step(1'b0, 21'h0, 1'b0, 1'b0);
    step(1'b0, 21'h0, 1'b1, 1'b0);

    // Zero angle, single start
    step(1'b1, 21'h000000, 1'b1, 1'b1);
    idle(6);

    // Negative bound
    step(1'b1, 21'h100000, 1'b1, 1'b1);
    idle(6);

    // Back-to-back operands
    step(1'b1, 21'h080000, 1'b1, 1'b1);
    step(1'b1, 21'h180000, 1'b1, 1'b1);
    step(1'b1, 21'h0FFFFF, 1'b1, 1'b1);
    idle(6);

    // Stall mid-pipeline; starts offered while stalled are ignored
    step(1'b1, 21'h040000, 1'b1, 1'b1);
    step(1'b0, 21'h0, 1'b1, 1'b1);
    step(1'b1, 21'h1C0000, 1'b0, 1'b1);
    step(1'b0, 21'h0, 1'b0, 1'b1);
    step(1'b0, 21'h0, 1'b0, 1'b1);
    idle(6);

    // Reset two cycles after start, then immediate restart
    step(1'b1, 21'h0A0000, 1'b1, 1'b1);
    idle(2);
    step(1'b0, 21'h0, 1'b1, 1'b0);
    step(1'b1, 21'h080000, 1'b1, 1'b1);
    idle(6);

    // Reset wins even while disabled
    step(1'b1, 21'h030000, 1'b1, 1'b1);
    idle(1);
    step(1'b0, 21'h0, 1'b0, 1'b0);
    idle(6);

    // Random sweep with occasional stall cycles
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) == 0) step(1'b1, 21'($urandom), 1'b0, 1'b1);
      step(1'b1, 21'($urandom), 1'b1, 1'b1);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_unroll4_var_fixed_point_input.md
CORDIC_UNROLL4_VAR_FIXED_POINT_INPUT -- requirements
Module: cordic_unroll4_var_fixed_point_input

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: aclr  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: clk_en  input  1  global enable; when 0, all registers hold their value.
REQ-004 SHALL have port: start  input  1  qualifies dataa as a new operand.
REQ-005 SHALL have port: dataa  input  21  angle in radians, signed two's complement Q1.20, range [-1.0, 1.0).
REQ-006 SHALL have port: result  output  32  cos(dataa) as an IEEE-754 single-precision value.
REQ-007 SHALL have port: done  output  1  result is valid for the operand whose start was accepted 5 enabled cycles earlier.
REQ-008 SHALL have parameter: LATENCY, default 5, meaning enabled cycles from start accepted to done.

Function
REQ-009 SHALL accept an operand on a rising edge when aclr=1, clk_en=1 and start=1.
REQ-010 SHALL compute cosine with rotation-mode CORDIC.
- Initial state: x = K = 0.6072529350, y = 0, z = dataa.
- Per iteration i, d = sign(z): x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan(2^-i).
REQ-011 SHALL run 16 iterations (i = 0..15), unrolled 4 per pipeline stage, giving 4 stage registers.
REQ-012 SHALL use a fixed internal datapath.
- x and y are signed 24-bit Q2.22.
- z is signed 24-bit Q2.22; dataa is sign-extended and shifted left by 2 into this format.
- Shifts are arithmetic; results are truncated, with no rounding.
REQ-013 SHALL convert final x to float in a fifth registered stage.
- x is in [0.5403, 1.0].
- Sign bit is 0.
- Normalise on the leading one, giving exponent 127 or 126.
- The mantissa is formed from the bits below the leading one, truncated to 23 bits.
- A value of x at or above 1.0 SHALL saturate to 0x3F800000.
REQ-014 SHALL be fully pipelined: one new operand accepted per enabled cycle, with independent results in order.
REQ-015 SHALL produce done as the start bit delayed through a 5-deep shift register that advances only when clk_en=1.
REQ-016 SHALL hold result and done stable while clk_en=0.
REQ-017 SHALL keep result at its last computed value when done=0; consumers qualify result with done.
REQ-018 SHALL keep absolute error |result - cos(dataa)| <= 2^-14 for all inputs in range.
REQ-019 SHALL treat dataa = 0x100000 (-1.0) as a valid input; there is no overflow at the negative bound.

Reset
REQ-020 SHALL clear the following on any rising edge with aclr=0, regardless of clk_en:
- all done/valid pipeline bits;
- all x, y, z stage registers;
- result, to 0x00000000.
REQ-021 SHALL discard operands in flight when reset is asserted mid-operation; no done is produced for them.
REQ-022 SHALL accept a new start on the first edge after aclr returns to 1.

Structure
REQ-023 SHALL place the following in shared package cordic_pkg:
- the atan(2^-i) table, i = 0..15, in Q2.22;
- constant K in Q2.22;
- datapath width constants.
REQ-024 SHALL implement one combinational sub-module, cordic_rotate4, which performs 4 consecutive micro-rotations from a base index; it is instantiated four times with base indices 0, 4, 8, 12.
REQ-025 SHALL keep the upstream operand preparation (float-to-fixed 8.13 conversion, then (x-128)/128 into Q1.20) in the existing blocks floating_to_fixed_8_13 and fixed_subtract_128, which are outside this block.

Verification
REQ-026 SHALL cover: dataa = 0x000000 with start for one cycle -> done=1 exactly 5 cycles later, result within 2^-14 of 1.0 (0x3F800000).
REQ-027 SHALL cover: dataa = 0x100000 (-1.0) -> result ~0x3F0A5140 (0.540302), error <= 2^-14.
REQ-028 SHALL cover: back-to-back starts with dataa = 0x080000 (0.5), 0x180000 (-0.5), 0x0FFFFF -> three consecutive done cycles giving, in order:
- 0.877583 (~0x3F60A940);
- 0.877583;
- ~0.540302.
REQ-029 SHALL cover: start, then clk_en=0 for 3 cycles mid-pipeline -> done delayed by exactly 3 cycles, and result equal to the unstalled value.
REQ-030 SHALL cover: aclr=0 asserted 2 cycles after start -> done never asserts for that operand, result=0x00000000.
REQ-031 SHALL cover: a random sweep of 10,000 dataa values -> every result is within 2^-14 of the reference cos.
